// File: rtl/button_event_capture.sv
// button_event_capture: sync, debounce, press/release/long detection
// and a 4-deep first-word-fall-through event queue for up to 8 pins.
//
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_btn             raw pins (async), polarity set by ACTIVE_LOW
//   o_level           debounced level, 1 = pressed
//   o_press/release   1-cycle pulses on accepted edges
//   o_long            1-cycle pulse when a hold reaches LONG_PRESS_CYCLES
//   o_evt_valid/data  queue head {chan[2:0], type[1:0]}; i_evt_ready pops
//   o_overflow        sticky, set when an event had to be dropped
module button_event_capture #(
   parameter int NUM_BTN           = 4,
   parameter bit ACTIVE_LOW        = 1'b1,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_long,
   output logic               o_evt_valid,
   input  logic               i_evt_ready,
   output logic [4:0]         o_evt_data,
   output logic               o_overflow
);

   typedef enum logic [1:0] {
      S_REL  = 2'd0,
      S_PRS  = 2'd1,
      S_HELD = 2'd2
   } state_t;

   localparam logic [NUM_BTN-1:0] IDLE_PIN = ACTIVE_LOW ? '1 : '0;
   localparam logic [19:0] DB_LIM = 20'(DEBOUNCE_CYCLES);
   localparam logic [26:0] LP_LIM = 27'(LONG_PRESS_CYCLES);

   logic [NUM_BTN-1:0] sync1, sync2, norm;
   logic [NUM_BTN-1:0] acc_p_v, acc_r_v, long_v;
   logic [NUM_BTN-1:0] pend_p, pend_l, pend_r;
   logic [NUM_BTN-1:0] clr_p, clr_l, clr_r, hit;
   logic               found, sel_p, sel_l;
   logic [2:0]         sel_ch;
   logic [1:0]         sel_type;
   logic               push, pop, full, ovf_set;
   logic [4:0]         mem [4];
   logic [1:0]         wr_ptr, rd_ptr;
   logic [2:0]         cnt;

   // Two-flop synchronizer, idle at the released pin level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1 <= IDLE_PIN;
         sync2 <= IDLE_PIN;
      end else begin
         sync1 <= i_btn;
         sync2 <= sync1;
      end
   end

   assign norm = ACTIVE_LOW ? ~sync2 : sync2;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic [19:0] db_cnt, db_inc, db_nxt;
      logic [26:0] hold_cnt, hold_inc, hold_nxt;
      logic        acc_p, acc_r, hold_hit, long_fire;
      state_t      st, st_nxt;

      assign db_inc = (db_cnt == '1) ? db_cnt : db_cnt + 20'd1;

      always_comb begin
         acc_p  = 1'b0;
         acc_r  = 1'b0;
         db_nxt = '0;
         if (norm[i] != o_level[i]) begin
            if (db_inc >= DB_LIM) begin
               acc_p = ~o_level[i];
               acc_r = o_level[i];
            end else begin
               db_nxt = db_inc;
            end
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) db_cnt <= '0;
         else          db_cnt <= db_nxt;
      end

      assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + 27'd1;
      assign hold_hit = hold_inc >= LP_LIM;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            st       <= S_REL;
            hold_cnt <= '0;
         end else begin
            st       <= st_nxt;
            hold_cnt <= hold_nxt;
         end
      end

      always_comb begin
         st_nxt = st;
         unique case (st)
            S_REL:   if (acc_p) st_nxt = S_PRS;
            S_PRS: begin
               if (acc_r)         st_nxt = S_REL;
               else if (hold_hit) st_nxt = S_HELD;
            end
            S_HELD:  if (acc_r) st_nxt = S_REL;
            default: st_nxt = S_REL;
         endcase
      end

      // Hold counter runs only in PRESSED; HELD freezes it
      always_comb begin
         long_fire = 1'b0;
         hold_nxt  = '0;
         unique case (st)
            S_PRS: begin
               long_fire = ~acc_r & hold_hit;
               hold_nxt  = acc_r ? '0 : hold_inc;
            end
            S_HELD:  hold_nxt = acc_r ? '0 : hold_cnt;
            default: hold_nxt = '0;
         endcase
      end

      assign acc_p_v[i] = acc_p;
      assign acc_r_v[i] = acc_r;
      assign long_v[i]  = long_fire;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_level   <= '0;
         o_press   <= '0;
         o_release <= '0;
         o_long    <= '0;
      end else begin
         o_level   <= o_level ^ (acc_p_v | acc_r_v);
         o_press   <= acc_p_v;
         o_release <= acc_r_v;
         o_long    <= long_v;
      end
   end

   // Lowest channel with anything pending wins
   always_comb begin
      found  = 1'b0;
      sel_ch = '0;
      hit    = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         if (!found && (pend_p[k] | pend_l[k] | pend_r[k])) begin
            found  = 1'b1;
            sel_ch = 3'(k);
            hit[k] = 1'b1;
         end
      end
   end

   assign sel_p = |(pend_p & hit);
   assign sel_l = |(pend_l & hit);

   always_comb begin
      sel_type = 2'b10;
      if (sel_p)      sel_type = 2'b01;
      else if (sel_l) sel_type = 2'b11;
   end

   assign full = (cnt == 3'd4);
   assign pop  = o_evt_valid & i_evt_ready;
   assign push = found & (~full | pop);

   assign clr_p = (push & sel_p) ? hit : '0;
   assign clr_l = (push & ~sel_p & sel_l) ? hit : '0;
   assign clr_r = (push & ~sel_p & ~sel_l) ? hit : '0;

   // A pulse is only lost when its bit is still held and not leaving now
   assign ovf_set = |(o_press & pend_p & ~clr_p)
                  | |(o_long & pend_l & ~clr_l)
                  | |(o_release & pend_r & ~clr_r);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_p     <= '0;
         pend_l     <= '0;
         pend_r     <= '0;
         o_overflow <= 1'b0;
      end else begin
         pend_p     <= (pend_p & ~clr_p) | o_press;
         pend_l     <= (pend_l & ~clr_l) | o_long;
         pend_r     <= (pend_r & ~clr_r) | o_release;
         o_overflow <= o_overflow | ovf_set;
      end
   end

   // When full, wr_ptr == rd_ptr: a simultaneous pop frees that slot
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 4; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {sel_ch, sel_type};
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         cnt <= cnt + {2'b00, push} - {2'b00, pop};
      end
   end

   assign o_evt_valid = (cnt != 3'd0);
   assign o_evt_data  = o_evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_capture.sv
// tb_button_event_capture: directed checks of debounce, long press,
// arbitration order, backpressure/overflow and reset behaviour.
module tb_button_event_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn;
   logic [3:0] o_level, o_press, o_release, o_long;
   logic       o_evt_valid, i_evt_ready, o_overflow;
   logic [4:0] o_evt_data;

   int total = 0;
   int bad   = 0;
   int press_total = 0;
   int long2_total = 0;
   int base;

   always #5 clk = ~clk;

   button_event_capture #(
      .NUM_BTN(4),
      .ACTIVE_LOW(1'b1),
      .DEBOUNCE_CYCLES(4),
      .LONG_PRESS_CYCLES(16)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_btn(btn),
      .o_level(o_level),
      .o_press(o_press),
      .o_release(o_release),
      .o_long(o_long),
      .o_evt_valid(o_evt_valid),
      .i_evt_ready(i_evt_ready),
      .o_evt_data(o_evt_data),
      .o_overflow(o_overflow)
   );

   always @(negedge clk) begin
      if (o_press != 4'b0000) press_total++;
      if (o_long[2])          long2_total++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n       = 1'b1;
      btn         = 4'hF;
      i_evt_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_level", 32'(o_level), 0);
      chk("rst_press", 32'(o_press), 0);
      chk("rst_release", 32'(o_release), 0);
      chk("rst_long", 32'(o_long), 0);
      chk("rst_valid", 32'(o_evt_valid), 0);
      chk("rst_data", 32'(o_evt_data), 0);
      chk("rst_ovf", 32'(o_overflow), 0);
      #9 rst_n = 1'b1;
      step(1);

      // clean press on channel 1
      btn[1] = 1'b0;
      step(5);
      chk("s1_press_early", 32'(o_press), 0);
      step(1);
      chk("s1_press", 32'(o_press), 'h2);
      chk("s1_level", 32'(o_level), 'h2);
      step(1);
      chk("s1_press_end", 32'(o_press), 0);
      chk("s1_valid_early", 32'(o_evt_valid), 0);
      step(1);
      chk("s1_valid", 32'(o_evt_valid), 1);
      chk("s1_data", 32'(o_evt_data), 32'b00101);
      i_evt_ready = 1'b1;
      step(1);
      chk("s1_popped", 32'(o_evt_valid), 0);
      btn[1] = 1'b1;
      step(6);
      chk("s1_release", 32'(o_release), 'h2);
      chk("s1_level_off", 32'(o_level), 0);
      step(2);
      chk("s1_rel_valid", 32'(o_evt_valid), 1);
      chk("s1_rel_data", 32'(o_evt_data), 32'b00110);
      step(1);
      chk("s1_rel_popped", 32'(o_evt_valid), 0);

      // bounce on channel 0
      base = press_total;
      for (int r = 0; r < 3; r++) begin
         btn[0] = 1'b0;
         step(3);
         btn[0] = 1'b1;
         step(2);
      end
      step(8);
      chk("s2_no_press", 32'(press_total - base), 0);
      chk("s2_level", 32'(o_level), 0);
      chk("s2_empty", 32'(o_evt_valid), 0);

      // long press on channel 2
      i_evt_ready = 1'b0;
      base = long2_total;
      btn[2] = 1'b0;
      step(6);
      chk("s3_press", 32'(o_press), 'h4);
      step(15);
      chk("s3_long_early", 32'(o_long), 0);
      step(1);
      chk("s3_long", 32'(o_long), 'h4);
      step(8);
      btn[2] = 1'b1;
      step(6);
      chk("s3_release", 32'(o_release), 'h4);
      chk("s3_level", 32'(o_level), 0);
      step(4);
      chk("s3_one_long", 32'(long2_total - base), 1);
      chk("s3_valid", 32'(o_evt_valid), 1);
      chk("s3_ev0", 32'(o_evt_data), 32'b01001);
      i_evt_ready = 1'b1;
      step(1);
      chk("s3_ev1", 32'(o_evt_data), 32'b01011);
      step(1);
      chk("s3_ev2", 32'(o_evt_data), 32'b01010);
      step(1);
      chk("s3_drained", 32'(o_evt_valid), 0);

      // simultaneous press on channels 3 and 0
      i_evt_ready = 1'b0;
      btn[0] = 1'b0;
      btn[3] = 1'b0;
      step(6);
      chk("s4_press", 32'(o_press), 'h9);
      step(4);
      chk("s4_valid", 32'(o_evt_valid), 1);
      chk("s4_ev0", 32'(o_evt_data), 32'b00001);
      i_evt_ready = 1'b1;
      step(1);
      chk("s4_ev1", 32'(o_evt_data), 32'b01101);
      step(1);
      chk("s4_drained", 32'(o_evt_valid), 0);
      btn[0] = 1'b1;
      btn[3] = 1'b1;
      step(13);
      chk("s4_rel_drained", 32'(o_evt_valid), 0);

      // backpressure and overflow
      i_evt_ready = 1'b0;
      btn[0] = 1'b0;
      btn[1] = 1'b0;
      step(7);
      btn[0] = 1'b1;
      btn[1] = 1'b1;
      btn[2] = 1'b0;
      step(7);
      btn[2] = 1'b1;
      step(7);
      chk("s5_ovf_clear", 32'(o_overflow), 0);
      chk("s5_valid", 32'(o_evt_valid), 1);
      chk("s5_head", 32'(o_evt_data), 32'b00001);
      btn[2] = 1'b0;
      step(6);
      chk("s5_repress", 32'(o_press), 'h4);
      chk("s5_ovf_still0", 32'(o_overflow), 0);
      step(1);
      chk("s5_ovf_set", 32'(o_overflow), 1);
      btn[2] = 1'b1;
      step(8);
      i_evt_ready = 1'b1;
      chk("s5_d0", 32'(o_evt_data), 32'b00001);
      step(1);
      chk("s5_d1", 32'(o_evt_data), 32'b00101);
      step(1);
      chk("s5_d2", 32'(o_evt_data), 32'b00010);
      step(1);
      chk("s5_d3", 32'(o_evt_data), 32'b00110);
      step(1);
      chk("s5_d4", 32'(o_evt_data), 32'b01001);
      step(1);
      chk("s5_d5", 32'(o_evt_data), 32'b01010);
      step(1);
      chk("s5_drained", 32'(o_evt_valid), 0);
      chk("s5_ovf_sticky", 32'(o_overflow), 1);

      // reset in the middle of a hold on channel 1
      i_evt_ready = 1'b0;
      btn[1] = 1'b0;
      step(10);
      chk("s6_level_pre", 32'(o_level), 'h2);
      chk("s6_valid_pre", 32'(o_evt_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("s6_rst_level", 32'(o_level), 0);
      chk("s6_rst_valid", 32'(o_evt_valid), 0);
      chk("s6_rst_data", 32'(o_evt_data), 0);
      chk("s6_rst_ovf", 32'(o_overflow), 0);
      chk("s6_rst_press", 32'(o_press), 0);
      #2 rst_n = 1'b1;
      step(5);
      chk("s6_press_early", 32'(o_press), 0);
      step(1);
      chk("s6_press", 32'(o_press), 'h2);
      chk("s6_level", 32'(o_level), 'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
